// File: rtl/dm_responder.sv
// Word-organised data store behind a req/ack handshake, with programmable wait states.
// Handles lw/sw/lb/sb and answers misaligned word accesses with err instead of touching the store.
module dm_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic              isbyte,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ack,
   output logic [31:0]       rdata,
   output logic              err,
   output logic              busy,
   output logic [1:0]        dbg_state
);
   // Handshake: req is taken only in IDLE with busy low; once taken the access always completes
   // (barring reset), and ack pulses for one cycle with rdata/err valid in that same cycle.
   // dbg_state encoding: 0 = IDLE, 1 = WAIT, 2 = RESP.
   localparam int         DEPTH     = 2 ** (ADDR_W - 2);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              isbyte_q, isbyte_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem_q [DEPTH];

   logic              accept;
   logic              misaligned;
   logic              mem_wr;
   logic [ADDR_W-3:0] word_idx;
   logic [1:0]        lane;
   logic [31:0]       mem_word;
   logic [31:0]       wr_word;
   logic [7:0]        lane_byte;

   assign word_idx   = addr_q[ADDR_W-1:2];
   assign lane       = addr_q[1:0];
   assign misaligned = !isbyte_q && (lane != 2'd0);
   assign mem_word   = mem_q[word_idx];
   // The ack cycle still has busy high, so a req held through ack is not re-taken there.
   assign accept     = (state_q == S_IDLE) && !busy_q && req;

   always_comb begin
      lane_byte = 8'h00;
      wr_word   = isbyte_q ? mem_word : wdata_q;
      for (int i = 0; i < 4; i++) begin
         if (lane == 2'(i)) begin
            lane_byte = mem_word[8*i +: 8];
            if (isbyte_q) wr_word[8*i +: 8] = wdata_q[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      we_d     = we_q;
      isbyte_d = isbyte_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = 32'h0;
      mem_wr   = 1'b0;
      if (accept) begin
         we_d     = we;
         isbyte_d = isbyte;
         addr_d   = addr;
         wdata_d  = wdata;
         busy_d   = 1'b1;
      end else if (ack_q) begin
         busy_d = 1'b0;
      end
      if (state_q == S_RESP) begin
         ack_d = 1'b1;
         if (misaligned)    err_d   = 1'b1;
         else if (we_q)     mem_wr  = 1'b1;
         else if (isbyte_q) rdata_d = {{24{lane_byte[7]}}, lane_byte};
         else               rdata_d = mem_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q     <= 1'b0;
         isbyte_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         we_q     <= we_d;
         isbyte_q <= isbyte_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // The store keeps its contents across reset; only a write landing on a reset edge is suppressed.
   always_ff @(posedge clk) begin
      if (rst && mem_wr) mem_q[word_idx] <= wr_word;
   end

   assign ack       = ack_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: one instance with 2 wait states and one with none, checked against
// a flat word-array model of the store plus the latency and handshake rules.
module tb_dm_responder;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req, we_s, isbyte_s, ack, err, busy;
   logic [ADDR_W-1:0] addr_s [2];
   logic [31:0]       wdata_s [2];
   logic [31:0]       rdata [2];
   logic [1:0]        dbg_state [2];
   logic [31:0]       model_mem [2][256];
   int                checks = 0;
   int                failures = 0;

   always #5 clk = ~clk;

   dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut_w2 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we_s[0]), .isbyte(isbyte_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]),
      .dbg_state(dbg_state[0])
   );

   dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_w0 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we_s[1]), .isbyte(isbyte_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]),
      .dbg_state(dbg_state[1])
   );

   function automatic int wait_of(input int inst);
      return (inst == 0) ? 2 : 0;
   endfunction

   // Reference: store is a plain array of words; lanes are picked by shifting.
   task automatic model_access(input int inst, input logic m_we, input logic m_isbyte,
                               input logic [9:0] m_addr, input logic [31:0] m_wdata,
                               output logic [31:0] e_rdata, output logic e_err);
      int         w;
      int         sh;
      logic [7:0] b;
      w       = int'(m_addr) / 4;
      sh      = (int'(m_addr) % 4) * 8;
      e_rdata = 32'h0;
      e_err   = 1'b0;
      if (!m_isbyte && (int'(m_addr) % 4) != 0) begin
         e_err = 1'b1;
      end else if (m_we && m_isbyte) begin
         model_mem[inst][w] = (model_mem[inst][w] & ~(32'hFF << sh)) | ({24'h0, m_wdata[7:0]} << sh);
      end else if (m_we) begin
         model_mem[inst][w] = m_wdata;
      end else if (m_isbyte) begin
         b       = 8'((model_mem[inst][w] >> sh) & 32'hFF);
         e_rdata = {{24{b[7]}}, b};
      end else begin
         e_rdata = model_mem[inst][w];
      end
   endtask

   // Drives one access; lat counts clock edges from the accept edge to the first edge showing ack.
   task automatic txn(input int inst, input logic t_we, input logic t_isbyte, input logic [9:0] t_addr,
                      input logic [31:0] t_wdata, input bit hold, output bit got_ack, output int lat,
                      output logic [31:0] got_rdata, output logic got_err, output logic busy_seen);
      @(negedge clk);
      req[inst] = 1'b1; we_s[inst] = t_we; isbyte_s[inst] = t_isbyte;
      addr_s[inst] = t_addr; wdata_s[inst] = t_wdata;
      @(posedge clk); #1;
      busy_seen = busy[inst];
      if (!hold) begin
         req[inst] = 1'b0; we_s[inst] = 1'($urandom); isbyte_s[inst] = 1'($urandom);
         addr_s[inst] = 10'($urandom); wdata_s[inst] = $urandom;
      end
      got_ack = 1'b0; lat = 0; got_rdata = 32'h0; got_err = 1'b0;
      for (int c = 1; c <= 40 && !got_ack; c++) begin
         @(posedge clk); #1;
         if (ack[inst]) begin
            got_ack = 1'b1; lat = c; got_rdata = rdata[inst]; got_err = err[inst];
         end
      end
      @(negedge clk);
      req[inst] = 1'b0;
   endtask

   task automatic access(input int inst, input logic a_we, input logic a_isbyte, input logic [9:0] a_addr,
                         input logic [31:0] a_wdata, input bit hold, output bit got_ack, output int lat,
                         output logic [31:0] got_rdata, output logic got_err, output logic busy_seen,
                         output logic [31:0] exp_rdata, output logic exp_err);
      model_access(inst, a_we, a_isbyte, a_addr, a_wdata, exp_rdata, exp_err);
      txn(inst, a_we, a_isbyte, a_addr, a_wdata, hold, got_ack, lat, got_rdata, got_err, busy_seen);
   endtask

   task automatic test_reset();
      rst = 1'b0; req = 2'b11; we_s = 2'b00; isbyte_s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         addr_s[i] = 10'h010; wdata_s[i] = 32'h0;
      end
      for (int cyc = 0; cyc < 2; cyc++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            checks++; if (ack[i] !== 1'b0) begin failures++; $display("FAIL reset_ack inst=%0d got=%b exp=0", i, ack[i]); end
            checks++; if (busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, busy[i]); end
            checks++; if (err[i] !== 1'b0) begin failures++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, err[i]); end
            checks++; if (rdata[i] !== 32'h0) begin failures++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", i, rdata[i]); end
            checks++; if (dbg_state[i] !== 2'd0) begin failures++; $display("FAIL reset_state inst=%0d got=%0d exp=0", i, dbg_state[i]); end
         end
      end
      @(negedge clk);
      rst = 1'b1; req = 2'b00;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (busy[i] !== 1'b0) begin failures++; $display("FAIL post_reset_busy inst=%0d got=%b exp=0", i, busy[i]); end
      end
   endtask

   task automatic test_word_rw();
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      access(0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ga !== 1'b1) begin failures++; $display("FAIL sw_ack got=%b exp=1", ga); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", lat); end
      checks++; if (bs !== 1'b1) begin failures++; $display("FAIL sw_busy_on_accept got=%b exp=1", bs); end
      checks++; if (gr !== 32'h0 || ge !== 1'b0) begin failures++; $display("FAIL sw_resp got=%h/%b exp=0/0", gr, ge); end
      access(0, 1'b0, 1'b0, 10'h010, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
      checks++; if (gr !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", gr); end
   endtask

   task automatic test_byte();
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      access(0, 1'b1, 1'b0, 10'h020, 32'h11223344, 1'b1, ga, lat, gr, ge, bs, er, ee);
      access(0, 1'b1, 1'b1, 10'h022, 32'hFFFFFF80, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ga !== 1'b1 || ge !== 1'b0 || gr !== 32'h0) begin failures++; $display("FAIL sb_resp got=%b/%b/%h exp=1/0/0", ga, ge, gr); end
      access(0, 1'b0, 1'b0, 10'h020, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'h11803344) begin failures++; $display("FAIL lw_after_sb got=%h exp=11803344", gr); end
      access(0, 1'b0, 1'b1, 10'h022, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_neg got=%h exp=ffffff80", gr); end
      access(0, 1'b0, 1'b1, 10'h020, 32'h0, 1'b0, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'h00000044) begin failures++; $display("FAIL lb_pos got=%h exp=00000044", gr); end
   endtask

   task automatic test_misaligned();
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      access(0, 1'b1, 1'b0, 10'h030, 32'h55667788, 1'b1, ga, lat, gr, ge, bs, er, ee);
      access(0, 1'b1, 1'b0, 10'h031, 32'hAAAAAAAA, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ga !== 1'b1 || lat !== 3) begin failures++; $display("FAIL mis_sw_ack got=%b lat=%0d exp=1 lat=3", ga, lat); end
      checks++; if (ge !== 1'b1 || gr !== 32'h0) begin failures++; $display("FAIL mis_sw_err got=%b/%h exp=1/0", ge, gr); end
      access(0, 1'b0, 1'b0, 10'h030, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'h55667788 || ge !== 1'b0) begin failures++; $display("FAIL mis_no_write got=%h/%b exp=55667788/0", gr, ge); end
      access(1, 1'b1, 1'b0, 10'h034, 32'h01020304, 1'b1, ga, lat, gr, ge, bs, er, ee);
      access(1, 1'b0, 1'b0, 10'h036, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ge !== 1'b1 || gr !== 32'h0) begin failures++; $display("FAIL mis_lw_err got=%b/%h exp=1/0", ge, gr); end
   endtask

   task automatic test_handshake();
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      access(0, 1'b1, 1'b0, 10'h050, 32'hA5A55A5A, 1'b0, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ga !== 1'b1 || lat !== 3) begin failures++; $display("FAIL drop_req_ack got=%b lat=%0d exp=1 lat=3", ga, lat); end
      access(0, 1'b0, 1'b0, 10'h050, 32'h0, 1'b0, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'hA5A55A5A) begin failures++; $display("FAIL drop_req_data got=%h exp=a5a55a5a", gr); end
      access(1, 1'b1, 1'b0, 10'h050, 32'h0BADF00D, 1'b0, ga, lat, gr, ge, bs, er, ee);
      checks++; if (ga !== 1'b1 || lat !== 1) begin failures++; $display("FAIL w0_sw_latency got=%b lat=%0d exp=1 lat=1", ga, lat); end
      checks++; if (bs !== 1'b1) begin failures++; $display("FAIL w0_busy_on_accept got=%b exp=1", bs); end
      access(1, 1'b0, 1'b0, 10'h050, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (lat !== 1 || gr !== 32'h0BADF00D) begin failures++; $display("FAIL w0_lw got=%h lat=%0d exp=0badf00d lat=1", gr, lat); end
   endtask

   task automatic test_back_to_back(input int inst);
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      int ack_cyc[$];
      int idle_cnt;
      int c;
      access(inst, 1'b1, 1'b0, 10'h060, 32'h600DCAFE, 1'b1, ga, lat, gr, ge, bs, er, ee);
      @(negedge clk);
      req[inst] = 1'b1; we_s[inst] = 1'b0; isbyte_s[inst] = 1'b0; addr_s[inst] = 10'h060;
      idle_cnt = 0; c = 0;
      while (ack_cyc.size() < 3 && c < 60) begin
         @(posedge clk); #1; c++;
         if (ack[inst]) begin
            ack_cyc.push_back(c);
            checks++; if (rdata[inst] !== 32'h600DCAFE) begin failures++; $display("FAIL b2b_data inst=%0d got=%h exp=600dcafe", inst, rdata[inst]); end
         end else if (!busy[inst] && ack_cyc.size() > 0) begin
            idle_cnt++;
         end
      end
      @(negedge clk);
      req[inst] = 1'b0;
      checks++;
      if (ack_cyc.size() !== 3) begin
         failures++; $display("FAIL b2b_ack_count inst=%0d got=%0d exp=3", inst, ack_cyc.size());
      end else if (ack_cyc[1] - ack_cyc[0] !== wait_of(inst) + 3 || ack_cyc[2] - ack_cyc[1] !== wait_of(inst) + 3) begin
         failures++; $display("FAIL b2b_interval inst=%0d got=%0d,%0d exp=%0d", inst,
                              ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1], wait_of(inst) + 3);
      end
      checks++; if (idle_cnt !== 2) begin failures++; $display("FAIL b2b_idle_cycles inst=%0d got=%0d exp=2", inst, idle_cnt); end
   endtask

   task automatic test_reset_mid_wait();
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      int spurious;
      access(0, 1'b1, 1'b0, 10'h040, 32'h12345678, 1'b1, ga, lat, gr, ge, bs, er, ee);
      @(negedge clk);
      req[0] = 1'b1; we_s[0] = 1'b1; isbyte_s[0] = 1'b0; addr_s[0] = 10'h040; wdata_s[0] = 32'hCAFEF00D;
      @(posedge clk); #1;
      checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL rmw_accept got=%b exp=1", busy[0]); end
      @(negedge clk);
      rst = 1'b0; req[0] = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy[0] !== 1'b0 || ack[0] !== 1'b0) begin failures++; $display("FAIL rmw_reset got=%b/%b exp=0/0", busy[0], ack[0]); end
      @(negedge clk);
      rst = 1'b1;
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack[0] || busy[0]) spurious++;
      end
      checks++; if (spurious !== 0) begin failures++; $display("FAIL rmw_dropped got=%0d exp=0", spurious); end
      access(0, 1'b0, 1'b0, 10'h040, 32'h0, 1'b1, ga, lat, gr, ge, bs, er, ee);
      checks++; if (gr !== 32'h12345678) begin failures++; $display("FAIL rmw_preserved got=%h exp=12345678", gr); end
   endtask

   task automatic test_random(input int inst);
      bit ga; int lat; logic [31:0] gr, er; logic ge, ee, bs;
      logic a_we, a_isbyte;
      logic [9:0] a_addr;
      for (int w = 0; w < 16; w++) begin
         access(inst, 1'b1, 1'b0, 10'(32'h100 + 4 * w), $urandom, 1'($urandom), ga, lat, gr, ge, bs, er, ee);
         checks++; if (ga !== 1'b1) begin failures++; $display("FAIL rnd_fill_ack inst=%0d word=%0d", inst, w); end
      end
      for (int n = 0; n < 60; n++) begin
         a_we     = 1'($urandom);
         a_isbyte = 1'($urandom);
         a_addr   = 10'(32'h100 + 4 * $urandom_range(0, 15));
         if (a_isbyte || $urandom_range(0, 3) == 0) a_addr[1:0] = 2'($urandom);
         access(inst, a_we, a_isbyte, a_addr, $urandom, 1'($urandom), ga, lat, gr, ge, bs, er, ee);
         checks++; if (ga !== 1'b1 || lat !== wait_of(inst) + 1) begin failures++; $display("FAIL rnd_latency inst=%0d n=%0d got=%b/%0d exp=1/%0d", inst, n, ga, lat, wait_of(inst) + 1); end
         checks++; if (gr !== er) begin failures++; $display("FAIL rnd_rdata inst=%0d n=%0d addr=%h we=%b byte=%b got=%h exp=%h", inst, n, a_addr, a_we, a_isbyte, gr, er); end
         checks++; if (ge !== ee) begin failures++; $display("FAIL rnd_err inst=%0d n=%0d addr=%h got=%b exp=%b", inst, n, a_addr, ge, ee); end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte();
      test_misaligned();
      test_handshake();
      test_back_to_back(0);
      test_back_to_back(1);
      test_reset_mid_wait();
      test_random(0);
      test_random(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
